// File: rtl/pe_acc_scatter.sv
// pe_acc_scatter: scatter-accumulates bundles of signed products into an
// out_size x out_size accumulator map, then streams the map out in raster order.
//
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready     bundle handshake
//   data_in               lanes x (2*word_length) signed products
//   data_in_cols/_rows    lanes x col_length coordinates per lane
//   in_last               bundle closes the current map
//   out_valid/out_ready   readout handshake
//   data_out              accumulated value (acc_width, signed)
//   out_col/out_row       coordinate of data_out
//   out_last              final readout word of the map
//   busy                  high whenever not IDLE
//
// Build option: define PE_ACC_RELU_EN to clamp negative readout values to zero.
module pe_acc_scatter #(
  parameter int unsigned word_length = 8,
  parameter int unsigned col_length  = 8,
  parameter int unsigned lanes       = 16,
  parameter int unsigned out_size    = 24,
  parameter int unsigned acc_width   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [lanes*2*word_length-1:0]    data_in,
  input  logic [lanes*col_length-1:0]       data_in_cols,
  input  logic [lanes*col_length-1:0]       data_in_rows,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [acc_width-1:0]       data_out,
  output logic [col_length-1:0]             out_col,
  output logic [col_length-1:0]             out_row,
  output logic                              out_last,
  output logic                              busy
);

  localparam int unsigned PW = 2 * word_length;
  localparam int unsigned N  = out_size * out_size;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = (lanes > 1) ? $clog2(lanes) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCUM, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          clr_addr_q, clr_addr_d;
  logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   hold_last_q, hold_last_d;
  logic [PW-1:0]          hold_prod_q [lanes];
  logic [PW-1:0]          hold_prod_d [lanes];
  logic [col_length-1:0]  hold_row_q [lanes];
  logic [col_length-1:0]  hold_row_d [lanes];
  logic [col_length-1:0]  hold_col_q [lanes];
  logic [col_length-1:0]  hold_col_d [lanes];
  logic [col_length-1:0]  fl_row_q, fl_row_d;
  logic [col_length-1:0]  fl_col_q, fl_col_d;
  logic [AW-1:0]          fl_addr_q, fl_addr_d;

  logic [acc_width-1:0]   mem [N];
  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [acc_width-1:0]   mem_wdata;

  logic [PW-1:0]          lane_prod;
  logic [col_length-1:0]  lane_row, lane_col;
  logic                   lane_hit;
  logic [AW-1:0]          lane_addr;
  logic [acc_width-1:0]   lane_sum;
  logic                   last_lane;
  logic                   in_fire, out_fire;
  logic [acc_width-1:0]   rd_word;

  // Current lane decode; one read-modify-write per cycle. The buffer is read
  // asynchronously, so lane i+1 sees the value lane i wrote at the prior edge
  // and same-address lanes within a bundle never lose updates.
  always_comb begin
    lane_prod = hold_prod_q[lane_cnt_q];
    lane_row  = hold_row_q[lane_cnt_q];
    lane_col  = hold_col_q[lane_cnt_q];
    lane_hit  = (32'(lane_row) < out_size) && (32'(lane_col) < out_size);
    lane_addr = AW'(32'(lane_row) * out_size + 32'(lane_col));
    lane_sum  = '0;
    if (lane_hit) begin
      lane_sum = mem[lane_addr] + {{(acc_width-PW){lane_prod[PW-1]}}, lane_prod};
    end
  end

  assign last_lane = (lane_cnt_q == LW'(lanes - 1));
  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_ACCUM) && last_lane && !hold_last_q);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == S_FLUSH);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    lane_cnt_d   = lane_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    hold_prod_d  = hold_prod_q;
    hold_row_d   = hold_row_q;
    hold_col_d   = hold_col_q;
    fl_row_d     = fl_row_q;
    fl_col_d     = fl_col_q;
    fl_addr_d    = fl_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        if (clr_addr_q == AW'(N - 1)) begin
          clr_addr_d = '0;
          state_d    = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end

      S_IDLE: begin
        // capture handled below
      end

      S_ACCUM: begin
        if (hold_valid_q && lane_hit) begin
          mem_we    = 1'b1;
          mem_waddr = lane_addr;
          mem_wdata = lane_sum;
        end
        if (last_lane) begin
          lane_cnt_d = '0;
          if (hold_last_q) begin
            hold_valid_d = 1'b0;
            fl_row_d     = '0;
            fl_col_d     = '0;
            fl_addr_d    = '0;
            state_d      = S_FLUSH;
          end else if (!in_fire) begin
            hold_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end else begin
          lane_cnt_d = lane_cnt_q + LW'(1);
        end
      end

      S_FLUSH: begin
        if (out_fire) begin
          // zero on readout so the next pass starts from a clean map
          mem_we    = 1'b1;
          mem_waddr = fl_addr_q;
          if (fl_addr_q == AW'(N - 1)) begin
            fl_row_d  = '0;
            fl_col_d  = '0;
            fl_addr_d = '0;
            state_d   = S_IDLE;
          end else begin
            fl_addr_d = fl_addr_q + AW'(1);
            if (fl_col_q == col_length'(out_size - 1)) begin
              fl_col_d = '0;
              fl_row_d = fl_row_q + col_length'(1);
            end else begin
              fl_col_d = fl_col_q + col_length'(1);
            end
          end
        end
      end

      default: state_d = S_CLEAR;
    endcase

    if (in_fire) begin
      state_d      = S_ACCUM;
      lane_cnt_d   = '0;
      hold_valid_d = 1'b1;
      hold_last_d  = in_last;
      for (int unsigned i = 0; i < lanes; i++) begin
        hold_prod_d[i] = data_in[i*PW +: PW];
        hold_row_d[i]  = data_in_rows[i*col_length +: col_length];
        hold_col_d[i]  = data_in_cols[i*col_length +: col_length];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      lane_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      fl_row_q     <= '0;
      fl_col_q     <= '0;
      fl_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      lane_cnt_q   <= lane_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      fl_row_q     <= fl_row_d;
      fl_col_q     <= fl_col_d;
      fl_addr_q    <= fl_addr_d;
    end
  end

  // Holding payload needs no reset: it is only consumed while hold_valid_q.
  always_ff @(posedge clk) begin
    hold_prod_q <= hold_prod_d;
    hold_row_q  <= hold_row_d;
    hold_col_q  <= hold_col_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_word = mem[fl_addr_q];

  always_comb begin
    data_out = '0;
    out_row  = '0;
    out_col  = '0;
    out_last = 1'b0;
    if (out_valid) begin
`ifdef PE_ACC_RELU_EN
      data_out = rd_word[acc_width-1] ? '0 : rd_word;
`else
      data_out = rd_word;
`endif
      out_row  = fl_row_q;
      out_col  = fl_col_q;
      out_last = (fl_addr_q == AW'(N - 1));
    end
  end

endmodule

// File: tb/tb_pe_acc_scatter.sv
// Self-checking bench for pe_acc_scatter (default parameters).
// A bench-side accumulator model is updated on every bundle handshake; when
// the final bundle goes in, the expected readout stream is queued and then
// popped against each out_valid/out_ready handshake.
module tb_pe_acc_scatter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] data_in = '0;
  logic [127:0] data_in_cols = '0;
  logic [127:0] data_in_rows = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic signed [31:0] data_out;
  logic [7:0]   out_col;
  logic [7:0]   out_row;
  logic         out_last;
  logic         busy;

  pe_acc_scatter #(
    .word_length(8),
    .col_length (8),
    .lanes      (16),
    .out_size   (24),
    .acc_width  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .data_in_cols(data_in_cols),
    .data_in_rows(data_in_rows),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .out_col     (out_col),
    .out_row     (out_row),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic signed [31:0] model [24][24];
  logic [15:0] bp [16];
  logic [7:0]  br [16];
  logic [7:0]  bc [16];

  task automatic clear_model();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        model[r][c] = '0;
  endtask

  task automatic fill_out_of_range();
    for (int i = 0; i < 16; i++) begin
      bp[i] = 16'h0001;
      br[i] = 8'd30;
      bc[i] = 8'd0;
    end
  endtask

  task automatic send_bundle(input logic last, input bit keep, output int hs);
    int n;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      data_in[i*16 +: 16]     = bp[i];
      data_in_rows[i*8 +: 8]  = br[i];
      data_in_cols[i*8 +: 8]  = bc[i];
    end
    in_last  = last;
    in_valid = 1'b1;
    hs = -1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL bundle_handshake: in_ready stayed %0b, required 1 within 200 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      hs = cyc;
      if (!keep) in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (br[i] < 8'd24 && bc[i] < 8'd24)
          model[br[i]][bc[i]] = model[br[i]][bc[i]] + {{16{bp[i][15]}}, bp[i]};
      end
    end
  endtask

  task automatic flush_check(input string tag, input bit toggle);
    int   guard;
    bit   rdy;
    exp_t e;
    exp_t act;
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        e.row  = 8'(r);
        e.col  = 8'(c);
        e.last = (r == 23) && (c == 23);
`ifdef PE_ACC_RELU_EN
        e.data = model[r][c][31] ? 32'd0 : model[r][c];
`else
        e.data = model[r][c];
`endif
        exp_q.push_back(e);
        model[r][c] = '0;
      end
    end
    guard = 0;
    rdy = 1'b1;
    while (exp_q.size() > 0 && guard < 5000) begin
      @(negedge clk);
      out_ready = toggle ? rdy : 1'b1;
      rdy = !rdy;
      #1;
      if (out_valid) begin
        act = {out_row, out_col, out_last, data_out};
        vectors++;
        if (act !== exp_q[0]) begin
          miscompares++;
          $display("FAIL %s word: got row=%0d col=%0d last=%0b data=%0d, required row=%0d col=%0d last=%0b data=%0d",
                   tag, act.row, act.col, act.last, $signed(act.data),
                   exp_q[0].row, exp_q[0].col, exp_q[0].last, $signed(exp_q[0].data));
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d words outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_flush: out_valid=%0b in_ready=%0b busy=%0b, required 0 1 0",
               tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset(input string tag);
    int n;
    bit saw_valid;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s reset_ctrl: in_ready=%0b out_valid=%0b out_last=%0b busy=%0b, required 0 0 0 1",
               tag, in_ready, out_valid, out_last, busy);
    end
    vectors++;
    if (data_out !== 32'sd0 || out_col !== 8'd0 || out_row !== 8'd0) begin
      miscompares++;
      $display("FAIL %s reset_data: data_out=%0d col=%0d row=%0d, required 0 0 0",
               tag, data_out, out_col, out_row);
    end
    rst = 1'b1;
    clear_model();
    n = 0;
    saw_valid = 1'b0;
    while (busy && n < 2000) begin
      if (out_valid) saw_valid = 1'b1;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 576) begin
      miscompares++;
      $display("FAIL %s clear_len: busy for %0d cycles, required 576", tag, n);
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL %s clear_quiet: out_valid seen=1 during clear, required 0", tag);
    end
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: in_ready=%0b busy=%0b, required 1 0", tag, in_ready, busy);
    end
  endtask

  task automatic test_single();
    int hs;
    int n;
    fill_out_of_range();
    bp[0] = 16'sd5;     br[0] = 8'd0; bc[0] = 8'd0;
    bp[3] = -16'sd7;    br[3] = 8'd0; bc[3] = 8'd0;
    send_bundle(1'b1, 1'b0, hs);
    n = 0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single mid_bundle: in_ready=%0b busy=%0b, required 0 1", in_ready, busy);
    end
    while (!out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL single flush_latency: out_valid after %0d cycles, required 16", n);
    end
    flush_check("single", 1'b0);
  endtask

  task automatic test_back_to_back();
    int hs1, hs2;
    for (int i = 0; i < 16; i++) begin
      bp[i] = 16'h0001; br[i] = 8'd2; bc[i] = 8'd3;
    end
    send_bundle(1'b0, 1'b1, hs1);
    send_bundle(1'b1, 1'b0, hs2);
    vectors++;
    if (hs2 - hs1 != 16) begin
      miscompares++;
      $display("FAIL b2b spacing: %0d cycles between handshakes, required 16", hs2 - hs1);
    end
    flush_check("b2b", 1'b0);
  endtask

  task automatic test_stall();
    int hs;
    for (int i = 0; i < 16; i++) begin
      bp[i] = 16'($urandom);
      br[i] = 8'($urandom_range(0, 25));
      bc[i] = 8'($urandom_range(0, 25));
    end
    br[5] = br[4]; bc[5] = bc[4];
    send_bundle(1'b1, 1'b0, hs);
    flush_check("stall", 1'b1);
    fill_out_of_range();
    send_bundle(1'b1, 1'b0, hs);
    flush_check("empty", 1'b1);
  endtask

  task automatic test_reset_mid();
    int hs;
    for (int i = 0; i < 16; i++) begin
      bp[i] = 16'd100; br[i] = 8'd5; bc[i] = 8'd5;
    end
    send_bundle(1'b0, 1'b0, hs);
    repeat (8) @(negedge clk);
    test_reset("mid");
    fill_out_of_range();
    bp[0] = 16'h0001; br[0] = 8'd23; bc[0] = 8'd23;
    send_bundle(1'b1, 1'b0, hs);
    flush_check("after_mid_reset", 1'b0);
  endtask

  task automatic test_sign();
    int hs;
    fill_out_of_range();
    bp[2] = 16'h8000; br[2] = 8'd1; bc[2] = 8'd1;
    bp[9] = 16'h8000; br[9] = 8'd1; bc[9] = 8'd1;
    send_bundle(1'b1, 1'b0, hs);
    vectors++;
    if (model[1][1] !== -32'sd65536) begin
      miscompares++;
      $display("FAIL sign model: %0d, required -65536", model[1][1]);
    end
    flush_check("sign", 1'b0);
  endtask

  initial begin
    clear_model();
    test_reset("por");
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_sign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
